// File: rtl/boid_integrator.sv
// Sequential boid position integrator: read, optional speed clamp, integrate, saturate, write back.
// Optional feature macro: BOID_SPEED_CLAMP_EN (speed band clamp with 27x27 multipliers).
module boid_integrator #(
   parameter int N_BOIDS = 16,
   parameter int ADDR_W  = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic signed [26:0]       maxspeed,
   input  logic signed [26:0]       minspeed,
   output logic                     busy,
   output logic                     done,
   output logic                     rd_en,
   output logic [ADDR_W-1:0]        rd_addr,
   input  logic signed [26:0]       rd_x,
   input  logic signed [26:0]       rd_y,
   input  logic signed [26:0]       rd_vx,
   input  logic signed [26:0]       rd_vy,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic signed [26:0]       wr_x,
   output logic signed [26:0]       wr_y,
   output logic signed [26:0]       wr_vx,
   output logic signed [26:0]       wr_vy
);

   typedef enum logic [2:0] {IDLE, RD, WAIT, CALC, WB, DONE} state_t;

   localparam logic signed [27:0] X_MAX = 28'(639 * 32768);
   localparam logic signed [27:0] Y_MAX = 28'(479 * 32768);
   localparam logic [ADDR_W-1:0]  LAST  = ADDR_W'(N_BOIDS - 1);

   state_t state, state_nxt;
   logic [ADDR_W-1:0] idx, idx_nxt;

   logic signed [26:0] cx, cy, cvx, cvy;
   logic signed [26:0] nx, ny, nvx, nvy;
   logic signed [26:0] vx_cl, vy_cl;
   logic signed [27:0] sum_x, sum_y;

`ifdef BOID_SPEED_CLAMP_EN
   logic signed [53:0] sq_vx, sq_vy, sq_max, sq_min;
   logic [54:0] s2;
   logic over, under;

   // Squares are non-negative, so the unsigned compare against the bounds is exact.
   assign sq_vx  = cvx * cvx;
   assign sq_vy  = cvy * cvy;
   assign sq_max = maxspeed * maxspeed;
   assign sq_min = minspeed * minspeed;
   assign s2     = {1'b0, sq_vx} + {1'b0, sq_vy};
   assign over   = s2 > {1'b0, sq_max};
   assign under  = s2 < {1'b0, sq_min};

   always_comb begin
      vx_cl = cvx;
      vy_cl = cvy;
      if (over) begin
         vx_cl = cvx - (cvx >>> 2);
         vy_cl = cvy - (cvy >>> 2);
      end else if (under) begin
         vx_cl = cvx + (cvx >>> 2);
         vy_cl = cvy + (cvy >>> 2);
      end
   end
`else
   logic unused_speed;
   assign unused_speed = ^{maxspeed, minspeed};
   assign vx_cl = cvx;
   assign vy_cl = cvy;
`endif

   assign sum_x = {cx[26], cx} + {vx_cl[26], vx_cl};
   assign sum_y = {cy[26], cy} + {vy_cl[26], vy_cl};

   function automatic logic signed [26:0] sat(input logic signed [27:0] v,
                                              input logic signed [27:0] hi);
      if (v < 0)
         return '0;
      else if (v > hi)
         return hi[26:0];
      else
         return v[26:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         idx   <= '0;
         cx    <= '0;
         cy    <= '0;
         cvx   <= '0;
         cvy   <= '0;
         nx    <= '0;
         ny    <= '0;
         nvx   <= '0;
         nvy   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (state == WAIT) begin
            cx  <= rd_x;
            cy  <= rd_y;
            cvx <= rd_vx;
            cvy <= rd_vy;
         end
         if (state == CALC) begin
            nx  <= sat(sum_x, X_MAX);
            ny  <= sat(sum_y, Y_MAX);
            nvx <= vx_cl;
            nvy <= vy_cl;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: if (start) begin
            idx_nxt   = '0;
            state_nxt = RD;
         end
         RD:   state_nxt = WAIT;
         WAIT: state_nxt = CALC;
         CALC: state_nxt = WB;
         WB: begin
            if (idx == LAST) begin
               state_nxt = DONE;
            end else begin
               idx_nxt   = idx + 1'b1;
               state_nxt = RD;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // All outputs come straight from registered state.
   assign busy    = (state != IDLE) && (state != DONE);
   assign done    = (state == DONE);
   assign rd_en   = (state == RD);
   assign rd_addr = idx;
   assign wr_en   = (state == WB);
   assign wr_addr = idx;
   assign wr_x    = nx;
   assign wr_y    = ny;
   assign wr_vx   = nvx;
   assign wr_vy   = nvy;

endmodule
